// File: rtl/logic_reduce_acc_if.sv
// Handshake bundle for logic_reduce_acc: lane-parallel beat input side and
// per-packet result output side.
interface logic_reduce_acc_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int CNT_W  = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_IN*WIDTH-1:0]   in_data;
   logic [1:0]                in_op;
   logic                      in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_data;
   logic [1:0]                out_op;
   logic [CNT_W-1:0]          out_beats;
   logic                      busy;

   modport master (
      output in_valid, in_data, in_op, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_op, out_beats, busy
   );

   modport slave (
      input  in_valid, in_data, in_op, in_last, out_ready,
      output in_ready, out_valid, out_data, out_op, out_beats, busy
   );
endinterface

// File: rtl/logic_reduce_acc.sv
// Reduces NUM_IN lanes per beat with OR/AND/XOR/NOR and accumulates across a
// packet, emitting one registered result per packet over valid/ready.
module logic_reduce_acc #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   logic_reduce_acc_if.slave  bus
);

   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic {IDLE, ACC} state_t;

   state_t             state;
   logic [WIDTH-1:0]   acc;
   logic [1:0]         op_q;
   logic [CNT_W-1:0]   cnt;

   logic [1:0]         beat_op;
   logic [WIDTH-1:0]   beat_red;
   logic [WIDTH-1:0]   combined;
   logic [CNT_W-1:0]   cnt_inc;
   logic               accept;

   // NOR shares the OR fold; the inversion happens only when the result is emitted
   function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] res;
      case (op)
         OP_AND:  res = a & b;
         OP_XOR:  res = a ^ b;
         default: res = a | b;
      endcase
      return res;
   endfunction

   function automatic logic [WIDTH-1:0] reduce(input logic [1:0] op,
                                               input logic [NUM_IN*WIDTH-1:0] d);
      logic [WIDTH-1:0] res;
      res = d[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         res = combine(op, res, d[k*WIDTH +: WIDTH]);
      end
      return res;
   endfunction

   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign bus.busy     = (state == ACC) || bus.out_valid;

   always_comb begin
      beat_op  = (state == IDLE) ? bus.in_op : op_q;
      beat_red = reduce(beat_op, bus.in_data);
      combined = (state == IDLE) ? beat_red : combine(op_q, acc, beat_red);
      cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
   end

   // A last beat accepted alongside a consumed result reloads out_* and keeps out_valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         op_q          <= OP_OR;
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_op    <= OP_OR;
         bus.out_beats <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (accept) begin
            if (bus.in_last) begin
               bus.out_data  <= (beat_op == OP_NOR) ? ~combined : combined;
               bus.out_op    <= beat_op;
               bus.out_beats <= (state == IDLE) ? CNT_W'(1) : cnt_inc;
               bus.out_valid <= 1'b1;
               state         <= IDLE;
            end else begin
               acc   <= combined;
               op_q  <= beat_op;
               cnt   <= (state == IDLE) ? CNT_W'(1) : cnt_inc;
               state <= ACC;
            end
         end
      end
   end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Self-checking bench for logic_reduce_acc: scoreboarded result stream,
// table of single-beat vectors and directed multi-beat corner cases.
module tb_logic_reduce_acc;

   logic clk;
   logic rst_n;

   logic_reduce_acc_if #(.WIDTH(8), .NUM_IN(4), .CNT_W(8)) bus ();
   logic_reduce_acc_if #(.WIDTH(8), .NUM_IN(4), .CNT_W(2)) bus_sat ();

   logic_reduce_acc #(.WIDTH(8), .NUM_IN(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic_reduce_acc #(.WIDTH(8), .NUM_IN(4), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_sat.slave)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] op;
      logic [7:0] beats;
   } exp_t;

   typedef struct {
      logic [31:0] lanes;
      logic [1:0]  op;
      logic [7:0]  exp_data;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushExpected(input logic [7:0] data, input logic [1:0] op,
                               input logic [7:0] beats);
      exp_t e;
      e.data  = data;
      e.op    = op;
      e.beats = beats;
      sb.push_back(e);
   endtask

   // Drives one beat and waits (bounded) until it is accepted; returns stall cycles
   task automatic applyStimulus(input logic [31:0] lanes, input logic [1:0] op,
                                input logic last, output int stalls);
      logic taken;
      bus.in_data  = lanes;
      bus.in_op    = op;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      stalls = 0;
      taken  = 1'b0;
      while (!taken && stalls < 50) begin
         @(negedge clk);
         taken = bus.in_ready;
         @(posedge clk);
         if (!taken) stalls++;
      end
      if (!taken) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got not accepted expected accepted");
      end
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Result scoreboard: every consumed output is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected: got result %0h expected none", bus.out_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb_data",  32'(bus.out_data),  32'(e.data));
            checkOutput("sb_op",    32'(bus.out_op),    32'(e.op));
            checkOutput("sb_beats", 32'(bus.out_beats), 32'(e.beats));
         end
      end
   end

   initial begin
      vec_t vecs[$];
      int   stalls;
      int   drain;

      vecs.push_back('{32'h80040201, 2'b00, 8'h87});
      vecs.push_back('{32'h000F55AA, 2'b10, 8'hF0});
      vecs.push_back('{32'h00000001, 2'b11, 8'hFE});
      vecs.push_back('{32'hF73F0FFF, 2'b01, 8'h07});
      vecs.push_back('{32'h00000000, 2'b00, 8'h00});
      vecs.push_back('{32'h00000000, 2'b11, 8'hFF});
      vecs.push_back('{32'hFFFFFFFF, 2'b01, 8'hFF});
      vecs.push_back('{32'h01010101, 2'b10, 8'h00});
      vecs.push_back('{32'h00010101, 2'b10, 8'h01});
      vecs.push_back('{32'h00000FF0, 2'b11, 8'h00});

      rst_n            = 1'b0;
      bus.in_valid     = 1'b0;
      bus.in_data      = '0;
      bus.in_op        = 2'b00;
      bus.in_last      = 1'b0;
      bus.out_ready    = 1'b1;
      bus_sat.in_valid = 1'b0;
      bus_sat.in_data  = '0;
      bus_sat.in_op    = 2'b00;
      bus_sat.in_last  = 1'b0;
      bus_sat.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
      checkOutput("rst_out_op",    32'(bus.out_op),    32'd0);
      checkOutput("rst_out_beats", 32'(bus.out_beats), 32'd0);
      checkOutput("rst_busy",      32'(bus.busy),      32'd0);
      checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] single-beat OR with latency check");
      pushExpected(8'h87, 2'b00, 8'd1);
      applyStimulus(32'h80040201, 2'b00, 1'b1, stalls);
      @(negedge clk);
      checkOutput("latency_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;

      $display("[TB] 3-beat AND packet with idle gap and in_op change");
      pushExpected(8'h30, 2'b01, 8'd3);
      applyStimulus(32'hFFFFFFFF, 2'b01, 1'b0, stalls);
      @(negedge clk);
      checkOutput("acc_busy",      32'(bus.busy),      32'd1);
      checkOutput("acc_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(32'hFFFFFFF0, 2'b10, 1'b0, stalls);
      applyStimulus(32'hFFFFFF3C, 2'b10, 1'b1, stalls);
      @(posedge clk);
      #1;

      $display("[TB] back-pressure hold and simultaneous consume/accept");
      bus.out_ready = 1'b0;
      pushExpected(8'hF0, 2'b10, 8'd1);
      applyStimulus(32'h000F55AA, 2'b10, 1'b1, stalls);
      bus.in_data  = 32'h80040201;
      bus.in_op    = 2'b00;
      bus.in_last  = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_in_ready",  32'(bus.in_ready),  32'd0);
         checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("bp_out_data",  32'(bus.out_data),  32'hF0);
         checkOutput("bp_out_beats", 32'(bus.out_beats), 32'd1);
         @(posedge clk);
      end
      #1;
      pushExpected(8'h87, 2'b00, 8'd1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp_valid_held", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_new_data",   32'(bus.out_data),  32'h87);
      @(posedge clk);
      #1;

      $display("[TB] reset mid-packet");
      applyStimulus(32'hFFFFFFFF, 2'b00, 1'b0, stalls);
      applyStimulus(32'hFFFFFFFF, 2'b00, 1'b0, stalls);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midrst_busy",      32'(bus.busy),      32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pushExpected(8'h0F, 2'b01, 8'd1);
      applyStimulus(32'hFFFFFF0F, 2'b01, 1'b1, stalls);

      $display("[TB] table of back-to-back single-beat packets");
      for (int i = 0; i < vecs.size(); i++) begin
         pushExpected(vecs[i].exp_data, vecs[i].op, 8'd1);
         applyStimulus(vecs[i].lanes, vecs[i].op, 1'b1, stalls);
         checkOutput("stream_stalls", 32'(stalls), 32'd0);
      end

      $display("[TB] saturating beat counter with CNT_W=2");
      for (int i = 0; i < 6; i++) begin
         bus_sat.in_data  = {24'h0, 8'(1 << i)};
         bus_sat.in_op    = 2'b00;
         bus_sat.in_last  = (i == 5);
         bus_sat.in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      bus_sat.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("sat_out_valid", 32'(bus_sat.out_valid), 32'd1);
      checkOutput("sat_out_data",  32'(bus_sat.out_data),  32'h3F);
      checkOutput("sat_out_beats", 32'(bus_sat.out_beats), 32'd3);

      drain = 0;
      while (sb.size() != 0 && drain < 20) begin
         @(posedge clk);
         drain++;
      end
      @(negedge clk);
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
